// File: rtl/dbg_reg_access_pkg.sv
// Shared types and constants for the debug abstract-command GPR access engine.
package dbg_reg_access_pkg;

    localparam int unsigned GPR_IDX_W      = 5;
    localparam logic [15:0] REGNO_BASE_DEF = 16'h1000;

    localparam logic [1:0] DBG_ERR_OK      = 2'd0;
    localparam logic [1:0] DBG_ERR_BADREG  = 2'd1;
    localparam logic [1:0] DBG_ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HALT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_RESUME = 3'd4
    } dbg_state_t;

    // Lower bound checked explicitly so a regno below the base cannot wrap into the window.
    function automatic logic regno_in_range(input logic [15:0] regno, input logic [15:0] base);
        logic [15:0] off;
        off = regno - base;
        return (regno >= base) && (off[15:GPR_IDX_W] == '0);
    endfunction

endpackage

// File: rtl/dbg_reg_access_halt_timer.sv
// Up-counting wait timer for the HALT state; o_expire marks the last permitted waiting cycle.
module dbg_reg_access_halt_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 8'd1;
    end

    assign o_expire = i_en && (r_count == LIMIT - 8'd1);

endmodule

// File: rtl/dbg_reg_access.sv
// Debug abstract-command engine: halts the core if needed, accesses a GPR over the debug port,
// returns a response and releases any halt it raised itself.
module dbg_reg_access
    import dbg_reg_access_pkg::*;
#(
    parameter logic [15:0] REGNO_BASE   = REGNO_BASE_DEF,
    parameter int unsigned HALT_TIMEOUT = 255,
    parameter bit          AUTO_RESUME  = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_write,
    input  logic [15:0]          i_cmd_regno,
    input  logic [31:0]          i_cmd_data,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic [31:0]          o_resp_data,
    output logic [1:0]           o_resp_err,
    output logic                 o_halt_req,
    input  logic                 i_halted,
    input  logic                 i_ex_we,
    output logic                 o_jtag_we,
    output logic [GPR_IDX_W-1:0] o_jtag_addr,
    output logic [31:0]          o_jtag_data,
    input  logic [31:0]          i_jtag_data
);

    // states: IDLE accept cmd | HALT wait halted | ACCESS GPR port | RESP hold response | RESUME release halt
    dbg_state_t           r_state, w_next;
    logic                 r_write, r_own_halt, r_halt_req;
    logic [GPR_IDX_W-1:0] r_idx;
    logic [31:0]          r_wdata, r_rdata;
    logic [1:0]           r_err;
    logic                 w_accept, w_regno_ok, w_expire, w_jtag_we, w_release;

    assign w_accept   = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_regno_ok = regno_in_range(i_cmd_regno, REGNO_BASE);
    assign w_release  = r_own_halt && AUTO_RESUME;

    dbg_reg_access_halt_timer #(
        .LIMIT(8'(HALT_TIMEOUT))
    ) u_halt_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (r_state != ST_HALT),
        .i_en    ((r_state == ST_HALT) && !i_halted),
        .o_expire(w_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_jtag_we = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (!w_regno_ok)
                        w_next = ST_RESP;
                    else if (i_halted)
                        w_next = ST_ACCESS;
                    else
                        w_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (i_halted)
                    w_next = ST_ACCESS;
                else if (w_expire)
                    w_next = ST_RESP;
            end
            ST_ACCESS: begin
                // The execute stage owns the GPR write port whenever it writes.
                if (!r_write || (r_idx == '0)) begin
                    w_next = ST_RESP;
                end else if (!i_ex_we) begin
                    w_jtag_we = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_resp_ready)
                    w_next = ST_RESUME;
            end
            ST_RESUME: begin
                if (!w_release || !i_halted)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_write    <= 1'b0;
            r_own_halt <= 1'b0;
            r_halt_req <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= DBG_ERR_OK;
        end else begin
            if (w_accept) begin
                r_write    <= i_cmd_write;
                r_wdata    <= i_cmd_data;
                r_rdata    <= '0;
                r_err      <= w_regno_ok ? DBG_ERR_OK : DBG_ERR_BADREG;
                r_own_halt <= w_regno_ok && !i_halted;
                if (w_regno_ok) begin
                    r_idx <= GPR_IDX_W'(i_cmd_regno - REGNO_BASE);
                    if (!i_halted)
                        r_halt_req <= 1'b1;
                end
            end
            if ((r_state == ST_HALT) && w_expire) begin
                r_err      <= DBG_ERR_TIMEOUT;
                r_halt_req <= 1'b0;
            end
            if ((r_state == ST_ACCESS) && !r_write)
                r_rdata <= i_jtag_data;
            if ((r_state == ST_RESP) && i_resp_ready && w_release)
                r_halt_req <= 1'b0;
        end
    end

    assign o_cmd_ready  = (r_state == ST_IDLE);
    assign o_resp_valid = (r_state == ST_RESP);
    assign o_resp_data  = r_rdata;
    assign o_resp_err   = r_err;
    assign o_halt_req   = r_halt_req;
    assign o_jtag_we    = w_jtag_we;
    assign o_jtag_addr  = r_idx;
    assign o_jtag_data  = r_wdata;

endmodule

// File: tb/tb_dbg_reg_access.sv
// Randomized bench for dbg_reg_access with a behavioural core, GPR file and transaction model.
module tb_dbg_reg_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_valid, i_cmd_write, i_resp_ready, i_halted, i_ex_we;
    logic [15:0] i_cmd_regno;
    logic [31:0] i_cmd_data, i_jtag_data;
    logic        o_cmd_ready, o_resp_valid, o_halt_req, o_jtag_we;
    logic [31:0] o_resp_data, o_jtag_data;
    logic [1:0]  o_resp_err;
    logic [4:0]  o_jtag_addr;

    logic [31:0] env_gpr [32];
    logic [31:0] ref_gpr [32];

    int n_vec = 0, n_bad = 0, cycles = 0;
    int ex_hold = 0, ack_delay = 0, ack_cnt = 0, rel_delay = 0, rel_cnt = 0;
    bit ex_rand = 0, ext_halt = 0, dbg_halted = 0, ack_en = 1, seen_halt_req = 0, prev_halted = 0;
    int pulses = 0, pulse_cycle = 0;
    logic [4:0]  pulse_addr;
    logic [31:0] pulse_data;

    always #5 clk = ~clk;

    assign i_jtag_data = env_gpr[o_jtag_addr];

    dbg_reg_access #(
        .REGNO_BASE  (16'h1000),
        .HALT_TIMEOUT(8),
        .AUTO_RESUME (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_write (i_cmd_write),
        .i_cmd_regno (i_cmd_regno),
        .i_cmd_data  (i_cmd_data),
        .o_resp_valid(o_resp_valid),
        .i_resp_ready(i_resp_ready),
        .o_resp_data (o_resp_data),
        .o_resp_err  (o_resp_err),
        .o_halt_req  (o_halt_req),
        .i_halted    (i_halted),
        .i_ex_we     (i_ex_we),
        .o_jtag_we   (o_jtag_we),
        .o_jtag_addr (o_jtag_addr),
        .o_jtag_data (o_jtag_data),
        .i_jtag_data (i_jtag_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycles);
        end
    endtask

    // One clock: core/ex react just after the edge, outputs observed at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        prev_halted = i_halted;
        if (seen_halt_req) begin
            rel_cnt = rel_delay;
            if (ack_en) begin
                if (ack_cnt > 0) ack_cnt--;
                else dbg_halted = 1;
            end
        end else begin
            ack_cnt = ack_delay;
            if (dbg_halted) begin
                if (rel_cnt > 0) rel_cnt--;
                else dbg_halted = 0;
            end
        end
        i_halted = ext_halt || dbg_halted;
        if (ex_hold > 0) begin
            i_ex_we = 1'b1;
            ex_hold--;
        end else begin
            i_ex_we = ex_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        @(negedge clk);
        cycles++;
        seen_halt_req = o_halt_req;
        if (o_jtag_we) begin
            pulses++;
            pulse_cycle = cycles;
            pulse_addr  = o_jtag_addr;
            pulse_data  = o_jtag_data;
            chk("we_while_ex_we", 32'(i_ex_we), 32'd0);
            if (o_jtag_addr != 5'd0) env_gpr[o_jtag_addr] = o_jtag_data;
        end
    endtask

    task automatic set_core(input bit ext, input bit ack, input int ad, input int rd);
        ext_halt  = ext;
        ack_en    = ack;
        ack_delay = ad;
        ack_cnt   = ad;
        rel_delay = rd;
        i_halted  = ext_halt || dbg_halted;
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
        chk({pfx, "_resp_valid"}, 32'(o_resp_valid), 32'd0);
        chk({pfx, "_resp_data"}, o_resp_data, 32'd0);
        chk({pfx, "_resp_err"}, 32'(o_resp_err), 32'd0);
        chk({pfx, "_halt_req"}, 32'(o_halt_req), 32'd0);
        chk({pfx, "_jtag_we"}, 32'(o_jtag_we), 32'd0);
        chk({pfx, "_jtag_addr"}, 32'(o_jtag_addr), 32'd0);
        chk({pfx, "_jtag_data"}, o_jtag_data, 32'd0);
    endtask

    task automatic run_cmd(input bit wr, input logic [15:0] regno, input logic [31:0] data,
                           input int stall, input int exh);
        bit          ok, own, exp_p;
        logic [4:0]  idx;
        logic [1:0]  e_err, s_err;
        logic [31:0] e_data, s_data;
        int          n, hc, acc;
        ok     = (regno >= 16'h1000) && (regno <= 16'h101F);
        idx    = 5'(regno - 16'h1000);
        own    = ok && !i_halted;
        e_err  = !ok ? 2'd1 : (own && !ack_en) ? 2'd2 : 2'd0;
        e_data = (e_err == 2'd0 && !wr) ? ref_gpr[idx] : 32'd0;
        exp_p  = (e_err == 2'd0) && wr && (idx != 5'd0);
        if (exp_p) ref_gpr[idx] = data;
        pulses  = 0;
        hc      = 0;
        ex_hold = exh;
        chk("ready_before_cmd", 32'(o_cmd_ready), 32'd1);
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_regno = regno;
        i_cmd_data  = data;
        step();
        i_cmd_valid = 1'b0;
        i_cmd_data  = $urandom;
        acc = cycles;
        n = 1;
        while (!o_resp_valid && n < 40) begin
            hc += int'(o_halt_req);
            step();
            n++;
        end
        chk("resp_valid_seen", 32'(o_resp_valid), 32'd1);
        s_data = o_resp_data;
        s_err  = o_resp_err;
        chk("resp_err", 32'(s_err), 32'(e_err));
        chk("resp_data", s_data, e_data);
        if (!ok) chk("latency_badreg", 32'(n), 32'd1);
        else if (!own && !wr) chk("latency_halted_read", 32'(n), 32'd2);
        if (!own) chk("halt_req_cycles_none", 32'(hc), 32'd0);
        else if (e_err == 2'd2) begin
            chk("halt_cycles_to_timeout", 32'(hc), 32'd8);
            chk("halt_req_at_timeout_resp", 32'(o_halt_req), 32'd0);
        end
        for (int k = 0; k < stall; k++) step();
        if (stall > 0) begin
            chk("resp_valid_held", 32'(o_resp_valid), 32'd1);
            chk("resp_data_held", o_resp_data, s_data);
            chk("resp_err_held", 32'(o_resp_err), 32'(s_err));
        end
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;
        n = 0;
        while (!o_cmd_ready && n < 40) begin
            step();
            n++;
        end
        chk("back_to_idle", 32'(o_cmd_ready), 32'd1);
        if (own) chk("idle_after_core_resumed", 32'(prev_halted), 32'd0);
        chk("halt_req_released", 32'(o_halt_req), 32'd0);
        chk("we_pulse_count", 32'(pulses), 32'(exp_p));
        if (exp_p) begin
            chk("we_addr", 32'(pulse_addr), 32'(idx));
            chk("we_data", pulse_data, data);
            if (exh > 0) chk("we_after_ex_release", 32'(pulse_cycle - acc), 32'(exh));
        end
    endtask

    initial begin
        logic [15:0] regno;
        int          r;
        rst          = 1'b1;
        i_cmd_valid  = 1'b0;
        i_cmd_write  = 1'b0;
        i_cmd_regno  = '0;
        i_cmd_data   = '0;
        i_resp_ready = 1'b0;
        i_halted     = 1'b0;
        i_ex_we      = 1'b0;
        for (int i = 0; i < 32; i++) begin
            env_gpr[i] = (i == 0) ? 32'd0 : $urandom;
            ref_gpr[i] = env_gpr[i];
        end
        repeat (2) @(negedge clk);
        check_reset("rst_init");
        rst = 1'b0;
        step();

        set_core(1, 1, 0, 0);
        run_cmd(1'b1, 16'h1005, 32'hDEADBEEF, 0, 0);

        env_gpr[10] = 32'h12345678;
        ref_gpr[10] = 32'h12345678;
        set_core(0, 1, 2, 2);
        run_cmd(1'b0, 16'h100A, 32'h0, 1, 0);

        set_core(0, 1, 1, 1);
        run_cmd(1'b1, 16'h1020, 32'hCAFEF00D, 0, 0);
        run_cmd(1'b0, 16'h0FFF, 32'h0, 0, 0);

        set_core(0, 0, 0, 0);
        run_cmd(1'b0, 16'h1001, 32'h0, 0, 0);

        set_core(1, 1, 0, 0);
        run_cmd(1'b1, 16'h1003, 32'hA5A5_0003, 0, 3);
        run_cmd(1'b0, 16'h1005, 32'h0, 0, 0);
        run_cmd(1'b1, 16'h1000, 32'h1234_0000, 5, 0);
        run_cmd(1'b0, 16'h1000, 32'h0, 0, 0);

        set_core(0, 0, 0, 0);
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b0;
        i_cmd_regno = 16'h1002;
        step();
        i_cmd_valid = 1'b0;
        step();
        step();
        chk("halt_req_before_rst", 32'(o_halt_req), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset("rst_async");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_resp_after_rst", 32'(o_resp_valid), 32'd0);
        end

        ex_rand = 1;
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) regno = 16'h1020 + 16'($urandom_range(0, 100));
            else if (r == 1) regno = 16'h1000 - 16'($urandom_range(1, 50));
            else regno = 16'h1000 + 16'($urandom_range(0, 31));
            set_core(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                     $urandom_range(0, 5), $urandom_range(0, 3));
            run_cmd(1'($urandom_range(0, 1)), regno, $urandom, $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
